vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator for the video path. It derives the pixel rate from the system clock with an internal divider and produces horizontal/vertical sync, a display-enable flag and pixel coordinates. Sync polarity, porch widths, resolution and output pipeline alignment are all set by parameters. It also emits line/frame boundary strobes for the pixel-generation logic downstream.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, active level of vga_hs (0 = active-low)
- VS_POL, 0, active level of vga_vs
- CLK_DIV, 2, system clocks per pixel, ≥1
- PIPE_DLY, 0, extra delay stages on vga_hs/vga_vs/video_on, 0..7
- CW, 10, counter width; 2^CW > max(H_TOTAL, V_TOTAL)
- clock_50  in  1  system clock
- reset_key  in  1  asynchronous reset, active-low
- enable  in  1  run enable; low freezes the raster
- pixel_tick  out  1  one-clock pixel-rate strobe
- pixel_x  out  CW  horizontal counter
- pixel_y  out  CW  vertical counter
- video_on  out  1  inside visible area (delayed)
- vga_hs  out  1  horizontal sync (delayed)
- vga_vs  out  1  vertical sync (delayed)
- line_end  out  1  strobe on last pixel of each line
- frame_end  out  1  strobe on last pixel of each frame

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 default). V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525 default).
- Horizontal regions in order: display [0, H_DISPLAY-1], front porch, sync [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], back porch. Vertical regions use the same order.
- Divider div_cnt counts 0..CLK_DIV-1 while enable=1.
  - pixel_tick = enable & (div_cnt == CLK_DIV-1).
  - For CLK_DIV=1, pixel_tick = enable.
- On pixel_tick, h_cnt advances and wraps to 0 after H_TOTAL-1.
- On pixel_tick with h_cnt = H_TOTAL-1, v_cnt advances and wraps to 0 after V_TOTAL-1.
- Wrap is detected by compare, never by overflow.
- line_end = pixel_tick & (h_cnt == H_TOTAL-1).
- frame_end = line_end & (v_cnt == V_TOTAL-1).
- Sync and display decode:
  - hs_raw = HS_POL when h_cnt is in the sync region, else ~HS_POL.
  - vs_raw is decoded the same way from v_cnt with VS_POL.
  - von_raw = (h_cnt < H_DISPLAY) & (v_cnt < V_DISPLAY).
- Raw signals are registered once, then pass through PIPE_DLY more clock_50 register stages, which shift every clock regardless of enable.
- pixel_x/pixel_y come directly from the counter registers.
- enable=0:
  - div_cnt, h_cnt and v_cnt hold their values.
  - pixel_tick, line_end and frame_end are 0.
  - The delay pipe keeps shifting, so outputs settle to the decode of the frozen position.

## Timing
- Reset (async assert, reset_key=0):
  - div_cnt, h_cnt, v_cnt = 0.
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL, video_on = 0.
  - All delay stages are loaded with these inactive values.
  - pixel_tick, line_end, frame_end = 0.
- First pixel_tick occurs CLK_DIV clocks after reset release with enable=1.
- vga_hs/vga_vs/video_on lag pixel_x/pixel_y by exactly 1+PIPE_DLY clock_50 cycles.
- Each pixel position is held CLK_DIV clocks. A line takes H_TOTAL·CLK_DIV clocks; a frame takes H_TOTAL·V_TOTAL·CLK_DIV clocks.
- Reset asserted mid-frame: all state and outputs return to reset values immediately, without waiting for a clock. Restart is at (0,0).
- On the frame wrap, line_end and frame_end assert in the same clock. The next clock shows pixel_x=0, pixel_y=0.

## Test plan
- Reset, then defaults: hold reset_key=0 → vga_hs=1, vga_vs=1, video_on=0, pixel_x=pixel_y=0. After release, pixel_x increments every 2 clocks.
- Line timing, defaults: per line, video_on is high for 1280 clocks and vga_hs is low for 192 clocks. vga_hs falls 1 clock after pixel_x becomes 656. line_end period = 1600 clocks.
- Frame timing, defaults: vga_vs is low only while pixel_y ∈ {490, 491} (1-clock lag). frame_end period = 840000 clocks, coincident with line_end. The next clock shows pixel_x=0, pixel_y=0.
- CLK_DIV=1, HS_POL=1, VS_POL=1, PIPE_DLY=3: pixel_tick is constantly 1. vga_hs rises 4 clocks after pixel_x=656 and stays high 96 clocks. vga_vs is active-high.
- Enable=0 at pixel_x=100: counters hold at 100 and strobes stay 0. Re-assert enable → pixel_x=101 after CLK_DIV clocks.
- Assert reset_key asynchronously at pixel_x=700, pixel_y=300: outputs take reset values before the next clock edge. Raster restarts from (0,0).

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator (master) and the
// downstream pixel-generation logic (slave).
interface vga_timing_gen_if #(
  parameter int unsigned CW = 10
);
  logic          enable;
  logic          pixel_tick;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          video_on;
  logic          vga_hs;
  logic          vga_vs;
  logic          line_end;
  logic          frame_end;

  modport master (
    input  enable,
    output pixel_tick, pixel_x, pixel_y, video_on, vga_hs, vga_vs, line_end, frame_end
  );

  modport slave (
    output enable,
    input  pixel_tick, pixel_x, pixel_y, video_on, vga_hs, vga_vs, line_end, frame_end
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clock divider, h/v counters, sync/display
// decode and a fixed-latency alignment pipe on the sync/display outputs.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned PIPE_DLY  = 0,
  parameter int unsigned CW        = 10
) (
  input  logic             clock_50,
  input  logic             reset_key,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_BEG = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_DISPLAY + V_FRONT;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;
  localparam int unsigned DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [2:0]  IDLE       = {1'b0, ~VS_POL, ~HS_POL};

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          div_last_c;
  logic          tick_c;
  logic          h_last_c;
  logic          v_last_c;
  logic [2:0]    raw_c;
  logic [2:0]    pipe_q [PIPE_DLY+1];

  assign div_last_c = (div_cnt == DW'(CLK_DIV - 1));
  assign tick_c     = reset_key & vga.enable & div_last_c;
  assign h_last_c   = (h_cnt == CW'(H_TOTAL - 1));
  assign v_last_c   = (v_cnt == CW'(V_TOTAL - 1));

  // Divider and raster counters; everything freezes while enable is low.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (vga.enable) begin
      div_cnt <= div_last_c ? '0 : div_cnt + DW'(1);
      if (tick_c) begin
        h_cnt <= h_last_c ? '0 : h_cnt + CW'(1);
        if (h_last_c) begin
          v_cnt <= v_last_c ? '0 : v_cnt + CW'(1);
        end
      end
    end
  end

  // Region decode of the current position, packed as {video_on, vs, hs}.
  always_comb begin
    raw_c    = IDLE;
    raw_c[0] = ((h_cnt >= CW'(H_SYNC_BEG)) && (h_cnt < CW'(H_SYNC_END))) ? HS_POL : ~HS_POL;
    raw_c[1] = ((v_cnt >= CW'(V_SYNC_BEG)) && (v_cnt < CW'(V_SYNC_END))) ? VS_POL : ~VS_POL;
    raw_c[2] = (h_cnt < CW'(H_DISPLAY)) && (v_cnt < CW'(V_DISPLAY));
  end

  // Alignment pipe shifts every clock, independent of enable.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      for (int i = 0; i <= int'(PIPE_DLY); i++) begin
        pipe_q[i] <= IDLE;
      end
    end else begin
      pipe_q[0] <= raw_c;
      for (int i = 1; i <= int'(PIPE_DLY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign vga.pixel_tick = tick_c;
  assign vga.line_end   = tick_c & h_last_c;
  assign vga.frame_end  = tick_c & h_last_c & v_last_c;
  assign vga.pixel_x    = h_cnt;
  assign vga.pixel_y    = v_cnt;
  assign vga.vga_hs     = pipe_q[PIPE_DLY][0];
  assign vga.vga_vs     = pipe_q[PIPE_DLY][1];
  assign vga.video_on   = pipe_q[PIPE_DLY][2];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized enable/reset bench for vga_timing_gen: two configurations are
// compared every clock against an arithmetic model of the raster.
module tb_vga_timing_gen;

  localparam int unsigned CW    = 10;
  localparam int unsigned NCYC  = 6000;

  typedef struct packed {
    int unsigned hd, hf, hs, hb, vd, vf, vs, vb;
    bit          hp, vp;
    int unsigned dv, dl;
  } cfg_t;

  typedef struct packed {
    logic          tick, le, fe, von, hs, vs;
    logic [CW-1:0] x, y;
  } obs_t;

  localparam cfg_t CA = '{hd: 16, hf: 4, hs: 6, hb: 6, vd: 8, vf: 2, vs: 2, vb: 3,
                          hp: 1'b0, vp: 1'b0, dv: 2, dl: 0};
  localparam cfg_t CB = '{hd: 12, hf: 3, hs: 5, hb: 4, vd: 6, vf: 2, vs: 3, vb: 2,
                          hp: 1'b1, vp: 1'b1, dv: 1, dl: 3};

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(CW)) bus_a ();
  vga_timing_gen_if #(.CW(CW)) bus_b ();

  assign bus_a.enable = en;
  assign bus_b.enable = en;

  vga_timing_gen #(
    .H_DISPLAY(CA.hd), .H_FRONT(CA.hf), .H_SYNC(CA.hs), .H_BACK(CA.hb),
    .V_DISPLAY(CA.vd), .V_FRONT(CA.vf), .V_SYNC(CA.vs), .V_BACK(CA.vb),
    .HS_POL(CA.hp), .VS_POL(CA.vp), .CLK_DIV(CA.dv), .PIPE_DLY(CA.dl), .CW(CW)
  ) u_dut_a (
    .clock_50 (clk),
    .reset_key(rst_n),
    .vga      (bus_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(CB.hd), .H_FRONT(CB.hf), .H_SYNC(CB.hs), .H_BACK(CB.hb),
    .V_DISPLAY(CB.vd), .V_FRONT(CB.vf), .V_SYNC(CB.vs), .V_BACK(CB.vb),
    .HS_POL(CB.hp), .VS_POL(CB.vp), .CLK_DIV(CB.dv), .PIPE_DLY(CB.dl), .CW(CW)
  ) u_dut_b (
    .clock_50 (clk),
    .reset_key(rst_n),
    .vga      (bus_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {bus_a.pixel_tick, bus_a.line_end, bus_a.frame_end, bus_a.video_on,
                  bus_a.vga_hs, bus_a.vga_vs, bus_a.pixel_x, bus_a.pixel_y};
  assign obs_b = {bus_b.pixel_tick, bus_b.line_end, bus_b.frame_end, bus_b.video_on,
                  bus_b.vga_hs, bus_b.vga_vs, bus_b.pixel_x, bus_b.pixel_y};

  // Model state: enabled clocks since reset, and decoded {von,vs,hs} history.
  longint     n_clk [2];
  logic [2:0] hist  [2][8];

  function automatic cfg_t cfg_of(input int k);
    return (k == 0) ? CA : CB;
  endfunction

  function automatic logic [2:0] idle_of(input cfg_t c);
    return {1'b0, ~c.vp, ~c.hp};
  endfunction

  // Position after cnt enabled clocks, from plain division.
  function automatic void pos_of(input cfg_t c, input longint cnt,
                                 output longint x, output longint y);
    longint ht = longint'(c.hd + c.hf + c.hs + c.hb);
    longint vt = longint'(c.vd + c.vf + c.vs + c.vb);
    longint p  = cnt / longint'(c.dv);
    x = p % ht;
    y = (p / ht) % vt;
  endfunction

  function automatic logic [2:0] raw_of(input cfg_t c, input longint cnt);
    longint x, y;
    logic   hs_in, vs_in;
    pos_of(c, cnt, x, y);
    hs_in = (x >= longint'(c.hd + c.hf)) && (x < longint'(c.hd + c.hf + c.hs));
    vs_in = (y >= longint'(c.vd + c.vf)) && (y < longint'(c.vd + c.vf + c.vs));
    return {(x < longint'(c.hd)) && (y < longint'(c.vd)),
            hs_in ? c.vp : ~c.vp,
            hs_in ? c.hp : ~c.hp} & 3'b111 & {1'b1, vs_in ? c.vp : ~c.vp, 1'b1}
           | {2'b00, 1'b0} & 3'b000
           | ({1'b0, vs_in ? c.vp : ~c.vp, 1'b0});
  endfunction

  function automatic obs_t expect_of(input int k);
    cfg_t   c = cfg_of(k);
    longint x, y;
    longint ht = longint'(c.hd + c.hf + c.hs + c.hb);
    longint vt = longint'(c.vd + c.vf + c.vs + c.vb);
    obs_t   o;
    pos_of(c, n_clk[k], x, y);
    o.tick = rst_n & en & ((n_clk[k] % longint'(c.dv)) == longint'(c.dv) - 1);
    o.le   = o.tick & (x == ht - 1);
    o.fe   = o.le & (y == vt - 1);
    o.von  = hist[k][c.dl][2];
    o.vs   = hist[k][c.dl][1];
    o.hs   = hist[k][c.dl][0];
    o.x    = CW'(x);
    o.y    = CW'(y);
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n_clk[k] = 0;
      for (int i = 0; i < 8; i++) hist[k][i] = idle_of(cfg_of(k));
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = raw_of(cfg_of(k), n_clk[k]);
      if (en) n_clk[k]++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_inst(input string nm, input obs_t o, input obs_t e);
    check({nm, ".pixel_tick"}, 32'(o.tick), 32'(e.tick));
    check({nm, ".line_end"},   32'(o.le),   32'(e.le));
    check({nm, ".frame_end"},  32'(o.fe),   32'(e.fe));
    check({nm, ".video_on"},   32'(o.von),  32'(e.von));
    check({nm, ".vga_hs"},     32'(o.hs),   32'(e.hs));
    check({nm, ".vga_vs"},     32'(o.vs),   32'(e.vs));
    check({nm, ".pixel_x"},    32'(o.x),    32'(e.x));
    check({nm, ".pixel_y"},    32'(o.y),    32'(e.y));
  endtask

  initial begin
    int rst_low = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (!rst_n) begin
        rst_low++;
        if (rst_low >= 3) begin
          rst_n   = 1'b1;
          rst_low = 0;
        end
      end else if (cyc == NCYC / 2 || $urandom_range(0, 1999) == 0) begin
        // Asynchronous reset mid-frame: outputs must clear before the next edge.
        rst_n = 1'b0;
        model_reset();
      end
      if (en) en = ($urandom_range(0, 19) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      #1;
      check_inst("a", obs_a, expect_of(0));
      check_inst("b", obs_b, expect_of(1));
      @(posedge clk);
      if (rst_n) model_clock();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
